// File: rtl/rst_seq_pkg.sv
// Shared types for the pl_clk0 reset sequencer.
// State encoding, widths and a release-time helper.
package rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Edge offset (from first locked sample) at which bit k is released
  function automatic int unsigned release_cycle(
    input int unsigned k,
    input int unsigned settle,
    input int unsigned step
  );
    return settle + k * step;
  endfunction

endpackage

// File: rtl/ext_rst_sequencer_if.sv
// Control/status bundle between platform glue and the reset sequencer.
// master drives lock/request inputs; slave is the sequencer.
interface ext_rst_sequencer_if #(
  parameter int NUM_RST = 4
) ();
  import rst_seq_pkg::*;

  logic               locked;
  logic               soft_req;
  logic               hb_toggle;
  logic               fault_clr;
  logic [NUM_RST-1:0] rst_out_n;
  logic               seq_done;
  logic               lock_lost;
  logic               hb_fault;
  logic [STATE_W-1:0] state_o;

  modport master (
    output locked, soft_req, hb_toggle, fault_clr,
    input  rst_out_n, seq_done, lock_lost,
    input  hb_fault, state_o
  );

  modport slave (
    input  locked, soft_req, hb_toggle, fault_clr,
    output rst_out_n, seq_done, lock_lost,
    output hb_fault, state_o
  );

endinterface

// File: rtl/rst_seq_timer.sv
// Loadable saturating down-counter; expired while the count is zero.
// Load takes priority over decrement.
module rst_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ext_rst_sequencer.sv
// Lock/settle reset sequencer releasing NUM_RST resets in index order.
// Define RST_SEQ_HB_EN to add the heartbeat watchdog and FAULT state.
module ext_rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_RST    = 4,
  parameter int SETTLE_CYC = 64,
  parameter int STEP_CYC   = 16,
  parameter int HB_TIMEOUT = 256,
  parameter int CNT_W      = 16
) (
  input logic          pl_clk0,
  input logic          pl_resetn,
  ext_rst_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LD   = CNT_W'(STEP_CYC - 1);
  localparam logic [NUM_RST-1:0] BIT0    = NUM_RST'(1);

  state_t state, state_d;

  logic [NUM_RST-1:0] rst_q, rst_d, rst_next;
  logic               done_q, done_d;
  logic               ll_q, hf_q;
  logic               ll_set, hf_set;
  logic               step;
  logic               tmr_load, tmr_exp;
  logic [CNT_W-1:0]   tmr_val;
  logic               wd_fault;

  assign rst_next = (rst_q << 1) | BIT0;

`ifdef RST_SEQ_HB_EN
  localparam logic [CNT_W-1:0] HB_LD = CNT_W'(HB_TIMEOUT - 1);

  logic hb_q, hb_edge, wd_exp, wd_load;

  always_ff @(posedge pl_clk0) begin
    if (!pl_resetn) hb_q <= 1'b0;
    else            hb_q <= bus.hb_toggle;
  end

  assign hb_edge  = bus.hb_toggle ^ hb_q;
  // Held loaded outside RUN so the window starts fresh on entry
  assign wd_load  = (state != RUN) || hb_edge;
  assign wd_fault = (state == RUN) && wd_exp && !hb_edge;

  rst_seq_timer #(.CNT_W(CNT_W)) u_wd (
    .clk      (pl_clk0),
    .rst_n    (pl_resetn),
    .load     (wd_load),
    .en       (1'b1),
    .load_val (HB_LD),
    .expired  (wd_exp)
  );
`else
  logic unused_hb;
  assign unused_hb = bus.hb_toggle;
  assign wd_fault  = 1'b0;
`endif

  always_comb begin
    state_d = state;
    rst_d   = rst_q;
    done_d  = done_q;
    ll_set  = 1'b0;
    hf_set  = 1'b0;
    step    = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (bus.locked) state_d = SETTLE;
      end
      SETTLE: begin
        if (!bus.locked || bus.soft_req) begin
          state_d = WAIT_LOCK;
        end else if (tmr_exp) begin
          rst_d   = rst_next;
          done_d  = &rst_next;
          state_d = (&rst_next) ? RUN : RELEASE;
        end
      end
      RELEASE, RUN: begin
        if (!bus.locked) begin
          state_d = WAIT_LOCK;
          ll_set  = 1'b1;
        end else if (wd_fault) begin
          state_d = FAULT;
          hf_set  = 1'b1;
        end else if (bus.soft_req) begin
          state_d = WAIT_LOCK;
        end else if (state == RELEASE && tmr_exp) begin
          step    = 1'b1;
          rst_d   = rst_next;
          done_d  = &rst_next;
          state_d = (&rst_next) ? RUN : RELEASE;
        end
      end
      FAULT: begin
        if (bus.soft_req) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
    // Every abort drops all outputs together
    if (state_d == WAIT_LOCK || state_d == FAULT) begin
      rst_d  = '0;
      done_d = 1'b0;
    end
  end

  always_comb begin
    tmr_load = (state_d != state) || step;
    tmr_val  = '0;
    if (state_d == SETTLE)  tmr_val = SETTLE_LD;
    if (state_d == RELEASE) tmr_val = STEP_LD;
  end

  rst_seq_timer #(.CNT_W(CNT_W)) u_tmr (
    .clk      (pl_clk0),
    .rst_n    (pl_resetn),
    .load     (tmr_load),
    .en       (1'b1),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_ff @(posedge pl_clk0) begin
    if (!pl_resetn) begin
      state  <= WAIT_LOCK;
      rst_q  <= '0;
      done_q <= 1'b0;
      ll_q   <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      state  <= state_d;
      rst_q  <= rst_d;
      done_q <= done_d;
      ll_q   <= ll_set ? 1'b1 : (bus.fault_clr ? 1'b0 : ll_q);
      hf_q   <= hf_set ? 1'b1 : (bus.fault_clr ? 1'b0 : hf_q);
    end
  end

  assign bus.rst_out_n = rst_q;
  assign bus.seq_done  = done_q;
  assign bus.lock_lost = ll_q;
  assign bus.hb_fault  = hf_q;
  assign bus.state_o   = state;

endmodule
